// File: rtl/lfsr_cipher_pkg.sv
// Shared types and helpers for the LFSR stream cipher: FSM states, default taps, keystream mapping.
package lfsr_cipher_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WARMUP = 2'd1,
      S_RUN    = 2'd2
   } state_e;

   // x^6 + x^5 + 1, maximal length for a 6-bit register
   localparam logic [5:0] DEFAULT_TAPS = 6'b110000;

   // Spread the LFSR state cyclically across a data word: ks[i] = st[i % key_w]
   function automatic logic [63:0] ks_word(input logic [63:0] st, input int key_w, input int data_w);
      logic [63:0] w;
      w = '0;
      for (int i = 0; i < 64; i++)
         if (i < data_w) w[i] = st[6'(i % key_w)];
      return w;
   endfunction

endpackage

// File: rtl/lfsr_stream_cipher_step.sv
// Combinational Fibonacci LFSR next-state: shift left, feedback parity of the tapped bits into bit 0.
module lfsr_step
   import lfsr_cipher_pkg::*;
#(
   parameter int               KEY_W = 6,
   parameter logic [KEY_W-1:0] TAPS  = DEFAULT_TAPS
) (
   input  logic [KEY_W-1:0] cur,
   output logic [KEY_W-1:0] nxt
);

   assign nxt = {cur[KEY_W-2:0], ^(cur & TAPS)};

endmodule

// File: rtl/lfsr_stream_cipher.sv
// LFSR keystream cipher with seed load, warm-up and valid/ready streaming; same block decrypts.
// Optional accepted-word counter port word_cnt when CIPHER_WORD_CNT_EN is defined.
module lfsr_stream_cipher
   import lfsr_cipher_pkg::*;
#(
   parameter int               KEY_W  = 6,
   parameter int               DATA_W = 8,
   parameter logic [KEY_W-1:0] TAPS   = DEFAULT_TAPS,
   parameter int               WARMUP = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [KEY_W-1:0]  seed,
   output logic              ready,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [KEY_W-1:0]  key
`ifdef CIPHER_WORD_CNT_EN
   ,output logic [15:0]      word_cnt
`endif
);

   localparam int WC_W = (WARMUP < 2) ? 1 : $clog2(WARMUP);

   state_e            state;
   logic [KEY_W-1:0]  lfsr;
   logic [KEY_W-1:0]  lfsr_nxt;
   logic [WC_W-1:0]   wcnt;
   logic [DATA_W-1:0] ks;
   logic              accept;

   lfsr_step #(.KEY_W(KEY_W), .TAPS(TAPS)) u_step (
      .cur (lfsr),
      .nxt (lfsr_nxt)
   );

   assign ks       = DATA_W'(ks_word(64'(lfsr), KEY_W, DATA_W));
   assign in_ready = (state == S_RUN) && !load && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign ready    = (state == S_RUN);
   assign key      = lfsr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         lfsr      <= KEY_W'(1);
         wcnt      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load) begin
         // all-zero state would lock the register up
         lfsr      <= (seed == '0) ? KEY_W'(1) : seed;
         state     <= S_WARMUP;
         wcnt      <= '0;
         out_valid <= 1'b0;
      end else begin
         if (state == S_WARMUP) begin
            lfsr <= lfsr_nxt;
            if (wcnt == WC_W'(WARMUP - 1)) begin
               state <= S_RUN;
               wcnt  <= '0;
            end else begin
               wcnt <= wcnt + 1'b1;
            end
         end
         if (accept) begin
            lfsr      <= lfsr_nxt;
            out_data  <= in_data ^ ks;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef CIPHER_WORD_CNT_EN
   always_ff @(posedge clk) begin
      if (rst || load)
         word_cnt <= '0;
      else if (accept)
         word_cnt <= word_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// Directed self-checking bench for lfsr_stream_cipher with hand-computed keystream vectors.
module tb_lfsr_stream_cipher;

   logic       clk = 1'b0;
   logic       rst, load, in_valid, out_ready;
   logic [5:0] seed;
   logic [7:0] in_data;
   logic       ready, in_ready, out_valid;
   logic [7:0] out_data;
   logic [5:0] key;
`ifdef CIPHER_WORD_CNT_EN
   logic [15:0] word_cnt;
`endif

   int checks = 0;
   int errors = 0;

   lfsr_stream_cipher dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .seed      (seed),
      .ready     (ready),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .key       (key)
`ifdef CIPHER_WORD_CNT_EN
      ,.word_cnt (word_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Independent reference: x^6+x^5+1 step and cyclic keystream mapping
   function automatic logic [5:0] m_step(input logic [5:0] s);
      return {s[4:0], s[5] ^ s[4]};
   endfunction

   function automatic logic [7:0] m_ks(input logic [5:0] s);
      return {s[1], s[0], s};
   endfunction

   task automatic test_reset;
      rst = 1'b1; load = 1'b0; seed = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      tick; tick;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
      checks++; if (key !== 6'h01) begin errors++; $display("FAIL reset_key got %h exp 01", key); end
`ifdef CIPHER_WORD_CNT_EN
      checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL reset_word_cnt got %0d exp 0", word_cnt); end
`endif
      rst = 1'b0;
      tick;
      checks++; if (key !== 6'h01 || ready !== 1'b0) begin errors++; $display("FAIL idle_hold got key %h ready %b exp 01 0", key, ready); end
   endtask

   task automatic test_warmup;
      load = 1'b1; seed = 6'h01;
      tick;
      load = 1'b0;
      checks++; if (key !== 6'h01 || ready !== 1'b0) begin errors++; $display("FAIL load_key got key %h ready %b exp 01 0", key, ready); end
      repeat (5) tick;
      checks++; if (key !== 6'b100001 || ready !== 1'b0) begin errors++; $display("FAIL warm5 got key %b ready %b exp 100001 0", key, ready); end
      tick;
      checks++; if (key !== 6'b000011) begin errors++; $display("FAIL warm_key got %b exp 000011", key); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL warm_ready got %b exp 1", ready); end
   endtask

   task automatic test_stream;
      out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h00;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL run_in_ready got %b exp 1", in_ready); end
      tick;
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hC3) begin errors++; $display("FAIL word0 got v%b %h exp v1 C3", out_valid, out_data); end
      checks++; if (key !== 6'b000110) begin errors++; $display("FAIL word0_key got %b exp 000110", key); end
      in_valid = 1'b0;
      tick;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain got %b exp 0", out_valid); end
      checks++; if (key !== 6'b000110) begin errors++; $display("FAIL idle_run_key got %b exp 000110", key); end
      in_valid = 1'b1; in_data = 8'h00;
      tick;
      checks++; if (out_data !== 8'h86) begin errors++; $display("FAIL word1 got %h exp 86", out_data); end
      checks++; if (key !== 6'b001100) begin errors++; $display("FAIL word1_key got %b exp 001100", key); end
      in_data = 8'hFF;
      tick;
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hF3) begin errors++; $display("FAIL word2 got v%b %h exp v1 F3", out_valid, out_data); end
      checks++; if (key !== 6'b011000) begin errors++; $display("FAIL word2_key got %b exp 011000", key); end
      in_valid = 1'b0;
      tick;
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
      tick;
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hBD) begin errors++; $display("FAIL bp_word got v%b %h exp v1 BD", out_valid, out_data); end
      in_data = 8'h3C;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
      tick; tick;
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hBD) begin errors++; $display("FAIL bp_hold got v%b %h exp v1 BD", out_valid, out_data); end
      checks++; if (key !== 6'b110001) begin errors++; $display("FAIL bp_key got %b exp 110001", key); end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", in_ready); end
      tick;
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h4D) begin errors++; $display("FAIL bp_next got v%b %h exp v1 4D", out_valid, out_data); end
      checks++; if (key !== 6'b100010) begin errors++; $display("FAIL bp_next_key got %b exp 100010", key); end
      in_valid = 1'b0;
      tick;
   endtask

   task automatic test_load_priority;
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h00;
      tick;
      load = 1'b1; seed = 6'h05;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ld_in_ready got %b exp 0", in_ready); end
      tick;
      load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ld_drop got %b exp 0", out_valid); end
      checks++; if (key !== 6'h05 || ready !== 1'b0) begin errors++; $display("FAIL ld_key got key %h ready %b exp 05 0", key, ready); end
   endtask

   task automatic test_seed_zero;
      load = 1'b1; seed = 6'h00;
      tick;
      load = 1'b0;
      checks++; if (key !== 6'h01) begin errors++; $display("FAIL seed0_load got %h exp 01", key); end
      repeat (6) tick;
      checks++; if (key !== 6'b000011 || ready !== 1'b1) begin errors++; $display("FAIL seed0_warm got key %b ready %b exp 000011 1", key, ready); end
   endtask

   task automatic test_round_trip;
      logic [7:0] pt [16];
      logic [7:0] ct [16];
      logic [5:0] m;
      m = 6'h2B;
      repeat (6) m = m_step(m);
      load = 1'b1; seed = 6'h2B;
      tick;
      load = 1'b0; out_ready = 1'b1;
      repeat (6) tick;
      for (int i = 0; i < 16; i++) begin
         pt[i] = 8'($urandom);
         in_valid = 1'b1; in_data = pt[i];
         tick;
         ct[i] = out_data;
         checks++;
         if (out_valid !== 1'b1 || out_data !== (pt[i] ^ m_ks(m))) begin
            errors++; $display("FAIL enc[%0d] got v%b %h exp v1 %h", i, out_valid, out_data, pt[i] ^ m_ks(m));
         end
         m = m_step(m);
      end
      in_valid = 1'b0;
      tick;
`ifdef CIPHER_WORD_CNT_EN
      checks++; if (word_cnt !== 16'd16) begin errors++; $display("FAIL cnt16 got %0d exp 16", word_cnt); end
`endif
      load = 1'b1; seed = 6'h2B;
      tick;
      load = 1'b0;
`ifdef CIPHER_WORD_CNT_EN
      checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL cnt_clr got %0d exp 0", word_cnt); end
`endif
      repeat (6) tick;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1; in_data = ct[i];
         tick;
         checks++;
         if (out_data !== pt[i]) begin errors++; $display("FAIL dec[%0d] got %h exp %h", i, out_data, pt[i]); end
      end
      in_valid = 1'b0;
      tick;
   endtask

   initial begin
      test_reset;
      test_warmup;
      test_stream;
      test_backpressure;
      test_load_priority;
      test_seed_zero;
      test_round_trip;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
